// File: rtl/inst_fetch_wide.sv
// Wide fetch front end: group-aligned requests, in-order responses queued as masked packets for decode.
// Response reaches decode one cycle later; decode stalls throttle issue through queue credits, responses are never refused.

`ifndef ADEL
`define ADEL 5'h04
`endif
`ifndef INVALID_EXCEP
`define INVALID_EXCEP 5'h1f
`endif

module inst_fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push_vld,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop_rdy,
  output logic [W-1:0]  o_pop_dat,
  output logic [CW-1:0] o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_push    = i_push_vld & (r_count != CW'(DEPTH));
  assign w_pop     = i_pop_rdy & (r_count != '0);
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Flush wins over a same-cycle push: the pushed entry belongs to the discarded stream.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end
endmodule

module inst_fetch_wide #(
  parameter int          FETCH_WIDTH     = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          IFQ_ENTRY       = 8,
  parameter logic [31:0] PC_INITIAL      = 32'hBFC00000,
  parameter logic [31:0] PC_EBASE        = 32'hBFC00380
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      is_exception,
  input  logic                      is_excep_return,
  input  logic [31:0]               excep_return_pc,
  input  logic                      is_jump_branch,
  input  logic [31:0]               jump_branch_address,
  output logic                      inst_addr_valid,
  input  logic                      inst_addr_ready,
  output logic [31:0]               inst_addr,
  input  logic                      inst_line_valid,
  output logic                      inst_line_ready,
  input  logic [32*FETCH_WIDTH-1:0] inst_line,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [32*FETCH_WIDTH-1:0] inst,
  output logic [FETCH_WIDTH-1:0]    inst_mask,
  output logic [31:0]               pc,
  output logic [4:0]                excep_code
);
  localparam int          FW_LOG      = $clog2(FETCH_WIDTH);
  localparam int          SW          = (FW_LOG > 0) ? FW_LOG : 1;
  localparam int          OW          = $clog2(MAX_OUTSTANDING + 1);
  localparam int          QCW         = $clog2(IFQ_ENTRY + 1);
  localparam logic [31:0] GROUP_BYTES = 32'(4 * FETCH_WIDTH);

  typedef struct packed {
    logic [31:0]            base;
    logic [FETCH_WIDTH-1:0] mask;
  } meta_t;

  typedef struct packed {
    logic [32*FETCH_WIDTH-1:0] inst;
    logic [31:0]               pc;
    logic [FETCH_WIDTH-1:0]    mask;
    logic [4:0]                code;
  } pkt_t;

  logic [31:0]            r_fetch_pc;
  logic [OW-1:0]          r_outstanding;
  logic [OW-1:0]          r_drop_cnt;
  logic                   r_halted;

  logic                   w_redirect;
  logic [31:0]            w_target;
  logic [31:0]            w_base;
  logic [SW-1:0]          w_slot;
  logic [FETCH_WIDTH-1:0] w_run_mask;
  logic [FETCH_WIDTH-1:0] w_one_mask;
  logic                   w_aligned;
  logic                   w_req_fire;
  logic                   w_rsp;
  logic                   w_rsp_keep;
  logic                   w_fault;
  logic [OW-1:0]          w_out_next;
  logic [OW-1:0]          w_meta_count;
  meta_t                  w_meta_push;
  meta_t                  w_meta_head;
  pkt_t                   w_q_push_pkt;
  pkt_t                   w_q_head;
  logic                   w_q_push;
  logic [QCW-1:0]         w_q_count;
  logic                   w_q_full;
  logic                   w_q_empty;

  assign w_redirect = is_exception | is_excep_return | is_jump_branch;
  assign w_target   = is_exception    ? PC_EBASE :
                      is_excep_return ? excep_return_pc : jump_branch_address;

  assign w_base    = r_fetch_pc & ~(GROUP_BYTES - 32'd1);
  assign w_slot    = (FW_LOG == 0) ? '0 : SW'(r_fetch_pc >> 2);
  assign w_aligned = (r_fetch_pc[1:0] == 2'b00);

  always_comb begin
    w_run_mask = '0;
    w_one_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_run_mask[i] = (i >= int'(w_slot));
      w_one_mask[i] = (i == int'(w_slot));
    end
  end

  assign w_q_full  = (int'(w_q_count) == IFQ_ENTRY);
  assign w_q_empty = (w_q_count == '0);

  // Queue entries plus requests in flight never exceed the queue depth, so every response has a slot.
  assign inst_addr_valid = ~rst & ~w_redirect & ~r_halted & w_aligned &
                           (int'(r_outstanding) < MAX_OUTSTANDING) &
                           ((int'(w_q_count) + int'(r_outstanding)) < IFQ_ENTRY);
  assign inst_addr       = w_base;
  assign inst_line_ready = 1'b1;
  assign w_req_fire      = inst_addr_valid & inst_addr_ready;

  assign w_rsp      = inst_line_valid & (w_meta_count != '0);
  assign w_rsp_keep = w_rsp & (r_drop_cnt == '0);
  assign w_fault    = ~rst & ~w_redirect & ~r_halted & ~w_aligned &
                      (r_outstanding == '0) & ~w_q_full;

  always_comb begin
    w_out_next = r_outstanding;
    if (w_req_fire && !w_rsp)      w_out_next = r_outstanding + OW'(1);
    else if (!w_req_fire && w_rsp) w_out_next = r_outstanding - OW'(1);
  end

  assign w_meta_push.base = w_base;
  assign w_meta_push.mask = w_run_mask;

  inst_fetch_fifo #(
    .W     ($bits(meta_t)),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (OW)
  ) u_meta_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (1'b0),
    .i_push_vld (w_req_fire),
    .i_push_dat (w_meta_push),
    .i_pop_rdy  (w_rsp),
    .o_pop_dat  (w_meta_head),
    .o_count    (w_meta_count)
  );

  always_comb begin
    w_q_push_pkt = '0;
    if (w_rsp_keep) begin
      w_q_push_pkt.inst = inst_line;
      w_q_push_pkt.pc   = w_meta_head.base;
      w_q_push_pkt.mask = w_meta_head.mask;
      w_q_push_pkt.code = `INVALID_EXCEP;
    end else begin
      w_q_push_pkt.pc   = w_base;
      w_q_push_pkt.mask = w_one_mask;
      w_q_push_pkt.code = `ADEL;
    end
  end

  assign w_q_push = w_rsp_keep | w_fault;

  inst_fetch_fifo #(
    .W     ($bits(pkt_t)),
    .DEPTH (IFQ_ENTRY),
    .CW    (QCW)
  ) u_pkt_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_redirect),
    .i_push_vld (w_q_push),
    .i_push_dat (w_q_push_pkt),
    .i_pop_rdy  (inst_valid & inst_ready),
    .o_pop_dat  (w_q_head),
    .o_count    (w_q_count)
  );

  assign inst_valid = ~rst & ~w_redirect & ~w_q_empty;
  assign inst       = w_q_head.inst;
  assign inst_mask  = w_q_head.mask;
  assign pc         = w_q_head.pc;
  assign excep_code = w_q_head.code;

  // Drop count covers everything still in flight after this cycle, including a request issued now.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= PC_INITIAL;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_halted   <= 1'b0;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_req_fire) r_fetch_pc <= w_base + GROUP_BYTES;
        if (w_fault)    r_halted   <= 1'b1;
        if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - OW'(1);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_wide.sv
`timescale 1ns/1ps
module tb_inst_fetch_wide;
  localparam logic [31:0] PC_INIT = 32'hBFC00000;
  localparam logic [31:0] EBASE   = 32'hBFC00380;
  localparam logic [4:0]  C_ADEL  = 5'h04;
  localparam logic [4:0]  C_NONE  = 5'h1f;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_exception = 1'b0, is_excep_return = 1'b0, is_jump_branch = 1'b0;
  logic [31:0] excep_return_pc = '0, jump_branch_address = '0;
  logic        inst_addr_valid, inst_addr_ready = 1'b1;
  logic [31:0] inst_addr;
  logic        inst_line_valid = 1'b0, inst_line_ready;
  logic [63:0] inst_line = '0;
  logic        inst_valid, inst_ready = 1'b1;
  logic [63:0] inst;
  logic [1:0]  inst_mask;
  logic [31:0] pc;
  logic [4:0]  excep_code;

  always #5 clk = ~clk;

  inst_fetch_wide dut (
    .clk(clk), .rst(rst),
    .is_exception(is_exception), .is_excep_return(is_excep_return),
    .excep_return_pc(excep_return_pc), .is_jump_branch(is_jump_branch),
    .jump_branch_address(jump_branch_address),
    .inst_addr_valid(inst_addr_valid), .inst_addr_ready(inst_addr_ready), .inst_addr(inst_addr),
    .inst_line_valid(inst_line_valid), .inst_line_ready(inst_line_ready), .inst_line(inst_line),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_mask(inst_mask), .pc(pc), .excep_code(excep_code)
  );

  typedef struct { logic [63:0] inst; logic [31:0] pc; logic [1:0] mask; logic [4:0] code; } pkt_t;
  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { bit exc; bit eret; bit jmp; logic [31:0] eret_pc; logic [31:0] jmp_pc; logic [31:0] exp_addr; } vec_t;

  pkt_t        sb[$];
  req_t        pend[$];
  pkt_t        e_pkt;
  req_t        r_new;
  int          n_cmp = 0, n_err = 0, cyc = 0, mem_lat = 1, mon_out = 0, n_issued = 0;
  logic [31:0] exp_pc = PC_INIT, last_req = '0, tgt;
  bit          exp_halted = 1'b0;

  function automatic logic [63:0] data_of(input logic [31:0] a);
    return {a ^ 32'h5A5A0001, a ^ 32'hA5A50000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_neg();
    @(negedge clk); #1;
  endtask

  // Memory: in-order responses, mem_lat cycles after acceptance.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      inst_line_valid = 1'b1;
      inst_line       = data_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      inst_line_valid = 1'b0;
      inst_line       = '0;
    end
  end

  // Monitor/scoreboard: expected packets follow the request stream since the last redirect.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete(); pend.delete();
      exp_pc = PC_INIT; exp_halted = 1'b0; mon_out = 0;
      chk("rst_addr_vld", inst_addr_valid, 0);
      chk("rst_inst_vld", inst_valid, 0);
    end else begin
      if (inst_line_valid) mon_out--;
      if (is_exception || is_excep_return || is_jump_branch) begin
        chk("redir_no_pop", inst_valid, 0);
        sb.delete();
        tgt = is_exception ? EBASE : (is_excep_return ? excep_return_pc : jump_branch_address);
        exp_pc = tgt; exp_halted = 1'b0;
        if (tgt[1:0] != 2'b00) begin
          exp_halted = 1'b1;
          e_pkt = '{64'h0, tgt & ~32'h7, tgt[2] ? 2'b10 : 2'b01, C_ADEL};
          sb.push_back(e_pkt);
        end
      end else begin
        if (exp_halted) chk("halt_no_req", inst_addr_valid, 0);
        if (inst_addr_valid && inst_addr_ready) begin
          chk("req_addr", inst_addr, exp_pc & ~32'h7);
          e_pkt = '{data_of(exp_pc & ~32'h7), exp_pc & ~32'h7, exp_pc[2] ? 2'b10 : 2'b11, C_NONE};
          sb.push_back(e_pkt);
          r_new = '{exp_pc & ~32'h7, cyc + mem_lat};
          pend.push_back(r_new);
          last_req = inst_addr;
          exp_pc = (exp_pc & ~32'h7) + 32'd8;
          mon_out++; n_issued++;
        end
        if (inst_valid && inst_ready) begin
          if (sb.size() == 0) chk("stale_pkt", 1, 0);
          else begin
            e_pkt = sb.pop_front();
            chk("pkt_pc", pc, e_pkt.pc);
            chk("pkt_mask", inst_mask, e_pkt.mask);
            chk("pkt_inst", inst, e_pkt.inst);
            chk("pkt_code", excep_code, e_pkt.code);
          end
        end
      end
    end
  end

  task automatic go_idle(input string name);
    tick();
    inst_addr_ready = 1'b0;
    for (int i = 0; i < 300 && (sb.size() != 0 || pend.size() != 0); i++) wait_neg();
    chk(name, (sb.size() == 0 && pend.size() == 0), 1);
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    int n0;
    n0 = n_issued;
    for (int i = 0; i < 50 && n_issued == n0; i++) wait_neg();
    chk({name, "_seen"}, (n_issued != n0), 1);
    chk({name, "_addr"}, last_req, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  int   n0;
  bit   seen;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'h00400040, EBASE};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h00400010, 32'h00400040, 32'h00400010};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h00400020, 32'h00400020};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h00400010, 32'h0,        EBASE};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h00400004, 32'h00400000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'h0000000C, 32'h00000008};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'hFFFFFFF8, 32'hFFFFFFF8};

    // Startup timing: request in first cycle, response next, packet one cycle later.
    repeat (3) tick();
    rst = 1'b0;
    wait_neg();
    chk("first_req_vld", inst_addr_valid, 1);
    chk("first_req_addr", inst_addr, PC_INIT);
    chk("c0_no_pkt", inst_valid, 0);
    tick(); wait_neg();
    chk("no_bypass", inst_valid, 0);
    tick(); wait_neg();
    chk("vld_after_rsp", inst_valid, 1);
    repeat (8) tick();

    // Redirect priority and alignment vectors.
    for (int k = 0; k < 7; k++) begin
      go_idle("tbl_idle");
      tick();
      inst_addr_ready = 1'b1;
      is_exception = tbl[k].exc; is_excep_return = tbl[k].eret; is_jump_branch = tbl[k].jmp;
      excep_return_pc = tbl[k].eret_pc; jump_branch_address = tbl[k].jmp_pc;
      tick();
      is_exception = 1'b0; is_excep_return = 1'b0; is_jump_branch = 1'b0;
      wait_req("tbl_req", tbl[k].exp_addr);
      repeat (4) tick();
    end

    // Redirect with three requests in flight; their responses must be dropped.
    go_idle("b_idle");
    tick();
    mem_lat = 5; inst_addr_ready = 1'b1;
    for (int i = 0; i < 50 && mon_out < 3; i++) wait_neg();
    chk("b_three_out", mon_out, 3);
    tick();
    inst_addr_ready = 1'b0; is_jump_branch = 1'b1; jump_branch_address = 32'h00400004;
    tick();
    is_jump_branch = 1'b0; inst_addr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      wait_neg();
      seen = inst_valid & inst_ready;
    end
    chk("b_pkt_seen", seen, 1);
    chk("b_first_pc", pc, 32'h00400000);
    chk("b_first_mask", inst_mask, 2'b10);
    repeat (10) tick();

    // Decode stall: issue caps at queue depth, then drains in order.
    go_idle("c_idle");
    tick();
    mem_lat = 1; inst_ready = 1'b0; n0 = n_issued; inst_addr_ready = 1'b1;
    repeat (40) tick();
    wait_neg();
    chk("c_credit_cap", n_issued - n0, 8);
    chk("c_issue_stopped", inst_addr_valid, 0);
    tick();
    inst_ready = 1'b1;
    go_idle("c_drain");

    // Misaligned exception-return target: one ADEL packet, no request, halted.
    tick();
    inst_addr_ready = 1'b1; is_excep_return = 1'b1; excep_return_pc = 32'h00400002;
    tick();
    is_excep_return = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_neg();
      seen = inst_valid;
    end
    chk("d_fault_seen", seen, 1);
    chk("d_fault_pc", pc, 32'h00400000);
    chk("d_fault_mask", inst_mask, 2'b01);
    chk("d_fault_code", excep_code, C_ADEL);
    repeat (20) tick();
    wait_neg();
    chk("d_single_pkt", sb.size(), 0);
    chk("d_halted_no_req", inst_addr_valid, 0);
    chk("d_no_more_pkt", inst_valid, 0);
    tick();
    is_jump_branch = 1'b1; jump_branch_address = 32'h00400100;
    tick();
    is_jump_branch = 1'b0;
    wait_req("d_resume", 32'h00400100);

    // Reset mid-stream with two requests outstanding.
    go_idle("e_idle");
    tick();
    mem_lat = 4; inst_addr_ready = 1'b1;
    for (int i = 0; i < 50 && mon_out < 2; i++) wait_neg();
    chk("e_two_out", mon_out, 2);
    tick();
    rst = 1'b1; inst_addr_ready = 1'b0;
    tick(); wait_neg();
    chk("e_rst_inst_vld", inst_valid, 0);
    chk("e_rst_addr_vld", inst_addr_valid, 0);
    tick();
    rst = 1'b0; inst_addr_ready = 1'b1; mem_lat = 1;
    wait_neg();
    chk("e_restart_vld", inst_addr_valid, 1);
    chk("e_restart_addr", inst_addr, PC_INIT);
    repeat (10) tick();
    go_idle("e_final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
